// File: rtl/ev19_soc_switch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ev19_switch_pkg
// Shared definitions for the DIP-switch controller:
//   - word offsets of the four bus-visible registers
//   - per-bit debounce state encoding
//   - reset value of the debounce period register (1 ms at 50 MHz)
// ---------------------------------------------------------------------------
package ev19_switch_pkg;

  localparam logic [1:0] ADDR_DATA       = 2'd0;
  localparam logic [1:0] ADDR_DEB_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP   = 2'd3;

  localparam int unsigned DEB_DEFAULT = 32'd50000;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/ev19_soc_switch_ctrl_if.sv
// ---------------------------------------------------------------------------
// ev19_soc_switch_ctrl_if
// Avalon-MM style register bus between the CPU and the switch controller.
//   address    2  word register select
//   chipselect 1  slave select, qualifies writes
//   write_n    1  active-low write strobe
//   writedata  32 write data
//   readdata   32 registered read data from the slave
// Modports: master (CPU side), slave (controller side).
// ---------------------------------------------------------------------------
interface ev19_soc_switch_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/ev19_soc_switch_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// ev19_switch_debounce
// One switch bit: two-flop synchroniser followed by the debounce FSM.
//   clk, reset_n  clock, asynchronous active-low reset
//   in_bit        raw pin, asynchronous to clk
//   period        debounce period in clk cycles (debounce build only)
//   stable_o      debounced level (registered)
//   edge_o        one-cycle pulse in the cycle whose clock edge updates stable_o
// Build option SWITCH_DEBOUNCE_EN: when undefined the FSM and counter are not
// built and the stable level simply follows the synchroniser with one flop.
// ---------------------------------------------------------------------------
module ev19_switch_debounce
  import ev19_switch_pkg::*;
#(
  parameter int unsigned DEB_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_bit,
`ifdef SWITCH_DEBOUNCE_EN
  input  logic [DEB_CNT_W-1:0] period,
`endif
  output logic                 stable_o,
  output logic                 edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic stable_q;
  logic stable_d;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_bit;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam logic [DEB_CNT_W-1:0] CNT_ONE = {{(DEB_CNT_W-1){1'b0}}, 1'b1};

  deb_state_e           state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

  // Debounce state, counter and stable level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Next-state logic; >= lets a lowered period take effect on the next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    edge_o   = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != stable_q) begin
          state_d = COUNTING;
          cnt_d   = '0;
        end else begin
          state_d = STABLE;
        end
      end
      COUNTING: begin
        if (sync2_q == stable_q) begin
          state_d = STABLE;            // glitch rejected
        end else if (cnt_q >= period) begin
          stable_d = sync2_q;
          edge_o   = 1'b1;
          state_d  = STABLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;               // saturate
        end
      end
      default: begin
        state_d = STABLE;
      end
    endcase
  end
`else
  // Stable level follows the synchroniser one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end

  // Every change of the synchronised level is an accepted edge.
  always_comb begin
    stable_d = sync2_q;
    edge_o   = sync2_q ^ stable_q;
  end
`endif

  assign stable_o = stable_q;

endmodule

// File: rtl/ev19_soc_switch_ctrl.sv
// ---------------------------------------------------------------------------
// ev19_soc_switch_ctrl
// Bus-mapped controller for the board DIP switches: synchronises and debounces
// each bit, records debounced edges in sticky flags and raises a maskable irq.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       register bus (slave modport): address/chipselect/write_n/
//             writedata in, readdata out (1-cycle registered read)
//   in_port   raw switch pins
//   irq       registered interrupt request, |(EDGE_CAP & IRQ_MASK)
// Registers: 0 DATA (RO), 1 DEB_PERIOD (RW), 2 IRQ_MASK (RW), 3 EDGE_CAP (W1C).
// Build option SWITCH_DEBOUNCE_EN enables the debounce counters; without it
// DEB_PERIOD reads 0 and ignores writes.
// ---------------------------------------------------------------------------
module ev19_soc_switch_ctrl
  import ev19_switch_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEB_CNT_W   = 16,
  parameter int unsigned DEB_DEFAULT = ev19_switch_pkg::DEB_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ev19_soc_switch_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_s;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;

`ifdef SWITCH_DEBOUNCE_EN
  localparam logic [DEB_CNT_W-1:0] DEB_RST = DEB_CNT_W'(DEB_DEFAULT);
  logic [DEB_CNT_W-1:0] deb_period_q, deb_period_d;
`endif

  assign wr_s = bus.chipselect & ~bus.write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ev19_switch_debounce #(.DEB_CNT_W(DEB_CNT_W)) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bit   (in_port[i]),
`ifdef SWITCH_DEBOUNCE_EN
      .period   (deb_period_q),
`endif
      .stable_o (stable_s[i]),
      .edge_o   (edge_s[i])
    );
  end

  // Bus registers, edge flags, irq and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
      readdata_q <= 32'd0;
`ifdef SWITCH_DEBOUNCE_EN
      deb_period_q <= DEB_RST;
`endif
    end else begin
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
`ifdef SWITCH_DEBOUNCE_EN
      deb_period_q <= deb_period_d;
`endif
    end
  end

  // Register writes, W1C with set-wins, irq and read mux.
  always_comb begin
    mask_d     = mask_q;
    clr_s      = '0;
    readdata_d = 32'd0;
`ifdef SWITCH_DEBOUNCE_EN
    deb_period_d = deb_period_q;
    if (wr_s && bus.address == ADDR_DEB_PERIOD) begin
      deb_period_d = bus.writedata[DEB_CNT_W-1:0];
    end else begin
      deb_period_d = deb_period_q;
    end
`endif
    if (wr_s && bus.address == ADDR_IRQ_MASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && bus.address == ADDR_EDGE_CAP) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    // A new edge is OR-ed in after the clear so it is never lost.
    edge_cap_d = (edge_cap_q & ~clr_s) | edge_s;
    irq_d      = |(edge_cap_q & mask_q);
    case (bus.address)
      ADDR_DATA:       readdata_d[WIDTH-1:0] = stable_s;
`ifdef SWITCH_DEBOUNCE_EN
      ADDR_DEB_PERIOD: readdata_d[DEB_CNT_W-1:0] = deb_period_q;
`else
      ADDR_DEB_PERIOD: readdata_d = 32'd0;
`endif
      ADDR_IRQ_MASK:   readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP:   readdata_d[WIDTH-1:0] = edge_cap_q;
      default:         readdata_d = 32'd0;
    endcase
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
